// File: rtl/stage_seq_pkg.sv
// Shared types for the stage sequencer: controller states and latched run mode.
package stage_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    AUTO   = 1'b0,
    MANUAL = 1'b1
  } mode_t;

endpackage

// File: rtl/stage_dwell_timer.sv
// Per-stage dwell counter: counts up from zero while enabled and flags the last
// cycle of the dwell window; a synchronous clear restarts it on stage entry.
module stage_dwell_timer #(
  parameter int DWELL_W = 8,
  parameter int DWELL   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [DWELL_W-1:0] LP_LAST = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DWELL_W'(1);
    end
  end

  assign o_expire = (r_cnt == LP_LAST);

endmodule

// File: rtl/stage_sequencer.sv
// N-stage process sequencer: auto (fixed dwell) or manual (per-stage step) runs
// with abort, a one-cycle completion pulse, and Moore-decoded enables/progress.
//
//   state | meaning
//   IDLE  | waiting for a start request; all outputs low
//   RUN   | stage r_stage active; advances on dwell expiry or its step bit
//   DONE  | single-cycle completion: led all ones, done pulse, then IDLE
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int DWELL_W    = 8,
  parameter int DWELL      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_auto,
  input  logic                          i_manual,
  input  logic [NUM_STAGES-1:0]         i_step,
  input  logic                          i_abort,
  output logic [NUM_STAGES-1:0]         o_en,
  output logic [NUM_STAGES-1:0]         o_led,
  output logic [$clog2(NUM_STAGES)-1:0] o_stage,
  output logic                          o_busy,
  output logic                          o_is_manual,
  output logic                          o_done
);

  localparam int            SW         = $clog2(NUM_STAGES);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  state_t        r_state, w_state_nxt;
  mode_t         r_mode, w_mode_nxt;
  logic [SW-1:0] r_stage, w_stage_nxt;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;
  logic w_adv;

  function automatic logic [NUM_STAGES-1:0] f_therm(input logic [SW-1:0] k);
    logic [NUM_STAGES-1:0] t;
    for (int i = 0; i < NUM_STAGES; i++) begin
      t[i] = (i <= int'(k));
    end
    return t;
  endfunction

  function automatic logic [NUM_STAGES-1:0] f_onehot(input logic [SW-1:0] k);
    logic [NUM_STAGES-1:0] t;
    for (int i = 0; i < NUM_STAGES; i++) begin
      t[i] = (i == int'(k));
    end
    return t;
  endfunction

  stage_dwell_timer #(
    .DWELL_W (DWELL_W),
    .DWELL   (DWELL)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= AUTO;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Timer clear defaults high so every exit from a stage (advance, abort,
  // completion) restarts the dwell count for whatever comes next.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_stage_nxt = r_stage;
    w_tmr_clr   = 1'b1;
    w_tmr_en    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        w_stage_nxt = '0;
        w_mode_nxt  = AUTO;
        if (!i_abort) begin
          if (i_manual) begin
            w_state_nxt = RUN;
            w_mode_nxt  = MANUAL;
          end else if (i_auto) begin
            w_state_nxt = RUN;
            w_mode_nxt  = AUTO;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_stage_nxt = '0;
          w_mode_nxt  = AUTO;
        end else begin
          w_adv = (r_mode == MANUAL) ? i_step[r_stage] : w_expire;
          if (w_adv) begin
            if (r_stage == LAST_STAGE) begin
              w_state_nxt = DONE;
              w_stage_nxt = '0;
            end else begin
              w_stage_nxt = r_stage + SW'(1);
            end
          end else if (r_mode == AUTO) begin
            w_tmr_clr = 1'b0;
            w_tmr_en  = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_stage_nxt = '0;
        w_mode_nxt  = AUTO;
      end
      default: begin
        w_state_nxt = IDLE;
        w_stage_nxt = '0;
        w_mode_nxt  = AUTO;
      end
    endcase
  end

  always_comb begin
    o_en    = '0;
    o_led   = '0;
    o_stage = '0;
    case (r_state)
      RUN: begin
        o_en    = f_onehot(r_stage);
        o_led   = f_therm(r_stage);
        o_stage = r_stage;
      end
      DONE: begin
        o_led = '1;
      end
      default: begin
        o_en = '0;
      end
    endcase
  end

  assign o_busy      = (r_state == RUN) || (r_state == DONE);
  assign o_done      = (r_state == DONE);
  assign o_is_manual = (r_state != IDLE) && (r_mode == MANUAL);

endmodule
